// File: rtl/inst_fetch_req.sv
// Fetch request stage: fetch PC, SRAM-like instruction request and one IF entry.
// IF_ADEF_CHECK_EN enables misaligned fetch exceptions (ADEF).
module inst_fetch_req #(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] PC_out,
   output logic [31:0] inst_out,
   output logic        inst_valid_out,
   output logic        discard_out,
   output logic        has_exception_out,
   output logic [5:0]  ecode_out,
   output logic [8:0]  esubcode_out,
   output logic        inst_req,
   output logic        inst_wr,
   output logic [1:0]  inst_size,
   output logic [31:0] inst_addr,
   output logic [3:0]  inst_wstrb,
   output logic [31:0] inst_wdata,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        ex_flush,
   input  logic [31:0] ex_entry,
   input  logic        ertn_flush,
   input  logic [31:0] era
);

   logic [31:0] fetch_pc;
   logic [31:0] redir_pc;
   logic [31:0] redir_tgt;
   logic [31:0] next_addr;
   logic [31:0] req_addr;
   logic        if_valid;
   logic        pending;
   logic        drop;
   logic        redir_valid;
   logic        redirect;
   logic        can_issue;
   logic        aligned;
   logic        adef;
   logic        hs;
   logic        handoff;

   assign inst_wr    = 1'b0;
   assign inst_size  = 2'd2;
   assign inst_wstrb = 4'h0;
   assign inst_wdata = 32'h0;

   assign redirect  = ex_flush | ertn_flush | br_taken;
   assign next_addr = redir_valid ? redir_pc : fetch_pc;

   always_comb begin
      redir_tgt = br_target;
      if (ex_flush)
         redir_tgt = ex_entry;
      else if (ertn_flush)
         redir_tgt = era;
   end

`ifdef IF_ADEF_CHECK_EN
   assign aligned  = (next_addr[1:0] == 2'b00);
   assign req_addr = next_addr;
`else
   // Low address bits are ignored rather than trapped.
   assign aligned  = 1'b1;
   assign req_addr = next_addr & ~32'h3;
`endif

   assign can_issue = !rst && !pending && !drop &&
                      (!if_valid || out_ready) && !redirect;
   assign inst_req  = can_issue && aligned;
   assign inst_addr = req_addr;
   assign hs        = inst_req && inst_addr_ok;
   assign adef      = can_issue && !aligned;
   assign handoff   = if_valid && out_ready && !redirect;

   assign out_valid   = if_valid;
   assign discard_out = !rst && redirect && pending && !inst_data_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc          <= RESET_PC;
         redir_pc          <= 32'h0;
         redir_valid       <= 1'b0;
         if_valid          <= 1'b0;
         pending           <= 1'b0;
         drop              <= 1'b0;
         PC_out            <= 32'h0;
         inst_out          <= 32'h0;
         inst_valid_out    <= 1'b0;
         has_exception_out <= 1'b0;
         ecode_out         <= 6'h0;
         esubcode_out      <= 9'h0;
      end else begin
         // Responses only count while a request is outstanding.
         if (inst_data_ok && pending) begin
            pending <= 1'b0;
            if (drop) begin
               drop <= 1'b0;
            end else if (if_valid && !inst_valid_out &&
                         !handoff && !redirect) begin
               inst_out       <= inst_rdata;
               inst_valid_out <= 1'b1;
            end
         end
         if (redirect) begin
            if_valid    <= 1'b0;
            redir_valid <= 1'b1;
            redir_pc    <= redir_tgt;
            if (pending && !inst_data_ok)
               drop <= 1'b1;
         end else if (hs) begin
            if_valid          <= 1'b1;
            PC_out            <= req_addr;
            inst_valid_out    <= 1'b0;
            has_exception_out <= 1'b0;
            ecode_out         <= 6'h0;
            esubcode_out      <= 9'h0;
            pending           <= 1'b1;
            fetch_pc          <= req_addr + 32'd4;
            redir_valid       <= 1'b0;
         end else if (adef) begin
            if_valid          <= 1'b1;
            PC_out            <= next_addr;
            inst_out          <= 32'h0;
            inst_valid_out    <= 1'b1;
            has_exception_out <= 1'b1;
            ecode_out         <= 6'h08;
            esubcode_out      <= 9'h0;
         end else if (handoff) begin
            if_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch_req.sv
// Directed self-checking bench for inst_fetch_req.
// Covers handshakes, back-pressure, redirects, ADEF and reset.
module tb_inst_fetch_req;

   logic        clk = 1'b0;
   logic        rst;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] PC_out;
   logic [31:0] inst_out;
   logic        inst_valid_out;
   logic        discard_out;
   logic        has_exception_out;
   logic [5:0]  ecode_out;
   logic [8:0]  esubcode_out;
   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic [3:0]  inst_wstrb;
   logic [31:0] inst_wdata;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        br_taken;
   logic [31:0] br_target;
   logic        ex_flush;
   logic [31:0] ex_entry;
   logic        ertn_flush;
   logic [31:0] era;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   inst_fetch_req dut (
      .clk(clk), .rst(rst), .out_ready(out_ready),
      .out_valid(out_valid), .PC_out(PC_out), .inst_out(inst_out),
      .inst_valid_out(inst_valid_out), .discard_out(discard_out),
      .has_exception_out(has_exception_out), .ecode_out(ecode_out),
      .esubcode_out(esubcode_out), .inst_req(inst_req), .inst_wr(inst_wr),
      .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata), .br_taken(br_taken), .br_target(br_target),
      .ex_flush(ex_flush), .ex_entry(ex_entry),
      .ertn_flush(ertn_flush), .era(era)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; out_ready = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
      br_taken = 1'b0; br_target = 32'h0;
      ex_flush = 1'b0; ex_entry = 32'h0;
      ertn_flush = 1'b0; era = 32'h0;
      tick; tick;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_pc", PC_out, 32'h0);
      chk("rst_inst_out", inst_out, 32'h0);
      chk("rst_inst_valid", 32'(inst_valid_out), 32'd0);
      chk("rst_discard", 32'(discard_out), 32'd0);
      chk("rst_req", 32'(inst_req), 32'd0);
      chk("rst_exc", 32'(has_exception_out), 32'd0);
      chk("rst_ecode", 32'(ecode_out), 32'd0);
      chk("const_size", 32'(inst_size), 32'd2);
      chk("const_wr", 32'(inst_wr), 32'd0);

      // Sequential fetch from the reset PC
      rst = 1'b0; out_ready = 1'b1; inst_addr_ok = 1'b1; #1;
      chk("req0", 32'(inst_req), 32'd1);
      chk("addr0", inst_addr, 32'h1c000000);
      tick;
      chk("ov0", 32'(out_valid), 32'd1);
      chk("pc0", PC_out, 32'h1c000000);
      chk("req_busy", 32'(inst_req), 32'd0);
      inst_data_ok = 1'b1; inst_rdata = 32'h11111111;
      tick;
      inst_data_ok = 1'b0; #1;
      chk("ov_handoff", 32'(out_valid), 32'd0);
      chk("req1", 32'(inst_req), 32'd1);
      chk("addr1", inst_addr, 32'h1c000004);
      tick;
      chk("ov1", 32'(out_valid), 32'd1);
      chk("pc1", PC_out, 32'h1c000004);

      // Back-pressure: data captured and held
      out_ready = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h02800000;
      tick;
      inst_data_ok = 1'b0; #1;
      chk("bp_ivalid", 32'(inst_valid_out), 32'd1);
      chk("bp_inst", inst_out, 32'h02800000);
      chk("bp_req", 32'(inst_req), 32'd0);
      tick; tick;
      chk("bp_hold_inst", inst_out, 32'h02800000);
      chk("bp_hold_pc", PC_out, 32'h1c000004);
      chk("bp_hold_ov", 32'(out_valid), 32'd1);
      out_ready = 1'b1; #1;
      chk("bp_rel_req", 32'(inst_req), 32'd1);
      chk("bp_rel_addr", inst_addr, 32'h1c000008);
      tick;
      chk("refill_ov", 32'(out_valid), 32'd1);
      chk("refill_pc", PC_out, 32'h1c000008);
      chk("refill_iv", 32'(inst_valid_out), 32'd0);

      // Branch while pending: stale response dropped
      br_taken = 1'b1; br_target = 32'h1c000100; inst_addr_ok = 1'b0; #1;
      chk("br_discard", 32'(discard_out), 32'd1);
      chk("br_req", 32'(inst_req), 32'd0);
      tick;
      br_taken = 1'b0; #1;
      chk("br_discard_end", 32'(discard_out), 32'd0);
      chk("br_ov", 32'(out_valid), 32'd0);
      chk("br_drop_req", 32'(inst_req), 32'd0);
      tick; tick;
      chk("br_wait_req", 32'(inst_req), 32'd0);
      inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef;
      tick;
      inst_data_ok = 1'b0; #1;
      chk("br_no_cap", 32'(inst_valid_out), 32'd0);
      chk("br_no_ov", 32'(out_valid), 32'd0);
      chk("br_req_go", 32'(inst_req), 32'd1);
      chk("br_addr", inst_addr, 32'h1c000100);

      // addr_ok stall: request held steady
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("stall_req", 32'(inst_req), 32'd1);
         chk("stall_addr", inst_addr, 32'h1c000100);
         chk("stall_ov", 32'(out_valid), 32'd0);
      end
      inst_addr_ok = 1'b1;
      tick;
      inst_addr_ok = 1'b0; #1;
      chk("stall_done_ov", 32'(out_valid), 32'd1);
      chk("stall_done_pc", PC_out, 32'h1c000100);

      // Exception beats branch; simultaneous data_ok is just stale
      ex_flush = 1'b1; ex_entry = 32'h1c008000;
      br_taken = 1'b1; br_target = 32'h1c000200;
      inst_data_ok = 1'b1; #1;
      chk("ex_no_discard", 32'(discard_out), 32'd0);
      tick;
      ex_flush = 1'b0; br_taken = 1'b0; inst_data_ok = 1'b0; #1;
      chk("ex_ov", 32'(out_valid), 32'd0);
      chk("ex_req", 32'(inst_req), 32'd1);
      chk("ex_addr", inst_addr, 32'h1c008000);
      inst_addr_ok = 1'b1;
      tick;
      inst_addr_ok = 1'b0; #1;
      chk("ex_pc", PC_out, 32'h1c008000);
      inst_data_ok = 1'b1;
      tick;
      inst_data_ok = 1'b0; #1;
      chk("ex_next_ov", 32'(out_valid), 32'd0);
      chk("ex_next_addr", inst_addr, 32'h1c008004);

      // ertn beats branch
      ertn_flush = 1'b1; era = 32'h1c000040;
      br_taken = 1'b1; br_target = 32'h1c000200; #1;
      chk("ertn_req", 32'(inst_req), 32'd0);
      chk("ertn_discard", 32'(discard_out), 32'd0);
      tick;
      ertn_flush = 1'b0; br_taken = 1'b0; #1;
      chk("ertn_addr", inst_addr, 32'h1c000040);

      // Misaligned branch target
      br_taken = 1'b1; br_target = 32'h1c000102;
      tick;
      br_taken = 1'b0; inst_addr_ok = 1'b1; #1;
`ifdef IF_ADEF_CHECK_EN
      chk("adef_req", 32'(inst_req), 32'd0);
      tick;
      inst_addr_ok = 1'b0; #1;
      chk("adef_ov", 32'(out_valid), 32'd1);
      chk("adef_exc", 32'(has_exception_out), 32'd1);
      chk("adef_ecode", 32'(ecode_out), 32'h08);
      chk("adef_esub", 32'(esubcode_out), 32'd0);
      chk("adef_iv", 32'(inst_valid_out), 32'd1);
      chk("adef_inst", inst_out, 32'h0);
      chk("adef_pc", PC_out, 32'h1c000102);
`else
      chk("mis_req", 32'(inst_req), 32'd1);
      chk("mis_addr", inst_addr, 32'h1c000100);
      tick;
      inst_addr_ok = 1'b0; #1;
      chk("mis_ov", 32'(out_valid), 32'd1);
      chk("mis_exc", 32'(has_exception_out), 32'd0);
      chk("mis_pc", PC_out, 32'h1c000100);
`endif

      // Reset mid-operation; late response ignored
      rst = 1'b1; #1;
      chk("mrst_req", 32'(inst_req), 32'd0);
      tick;
      rst = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hcafef00d; #1;
      chk("mrst_ov", 32'(out_valid), 32'd0);
      chk("mrst_req1", 32'(inst_req), 32'd1);
      chk("mrst_addr", inst_addr, 32'h1c000000);
      tick;
      inst_data_ok = 1'b0; #1;
      chk("mrst_iv", 32'(inst_valid_out), 32'd0);
      chk("mrst_ov2", 32'(out_valid), 32'd0);
      chk("mrst_req2", 32'(inst_req), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
